// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipeline control logic.
// Holds the opcode encodings, the EX operand-forwarding select and the
// width helper for the data-memory wait counter.
package otter_pkg;

    // RV32I major opcodes seen by the OTTER decoder
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_t;

    // Source of an EX-stage operand
    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    // Wait-counter width for the default single-cycle data memory
    localparam int DMEM_LAT_DEFAULT = 1;
    localparam int WCNT_W = $clog2(DMEM_LAT_DEFAULT + 1);

    // Wait-counter width for an arbitrary data-memory latency
    function automatic int wcnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/otter_dmem_wait.sv
// Data-memory wait tracker for the OTTER MEM stage.
// Counts the cycles an access has spent in MEM and raises mem_busy until
// the access has been held for DMEM_LAT cycles in total.
module otter_dmem_wait
    import otter_pkg::*;
#(
    parameter int DMEM_LAT = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ex_mem_valid,
    input  logic mem_access,
    output logic mem_busy
);

    localparam int W = wcnt_width(DMEM_LAT);
    localparam logic [W-1:0] LAST = W'(DMEM_LAT - 1);

    logic [W-1:0] wcnt;

    // The counter never passes LAST, so "not yet at LAST" is the same as "below LAST"
    assign mem_busy = ex_mem_valid & mem_access & (wcnt != LAST);

    // Count cycles spent on the current access; clear once MEM moves on
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wcnt <= {W{1'b0}};
        end else if (mem_busy) begin
            wcnt <= wcnt + W'(1);
        end else begin
            wcnt <= {W{1'b0}};
        end
    end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Hazard and valid-bit controller for the 5-stage OTTER pipeline.
// Owns the per-stage valid bits, produces the stall_* controls and the EX
// operand-forwarding selects. Handles load-use and taken-branch flushes and
// multi-cycle data memory.
// Build option: define OTTER_FORWARD_EN to enable EX operand forwarding; without
// it every read-after-write dependency is resolved by stalling DE.
module otter_hazard_ctrl
    import otter_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DMEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              ex_rs1_used,
    input  logic              ex_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              ex_is_load,
    input  logic              mem_access,
    input  logic              branch_taken,
    output logic              stall_pc,
    output logic              stall_if,
    output logic              stall_de,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              if_de_valid,
    output logic              de_ex_valid,
    output logic              ex_mem_valid,
    output logic              mem_wb_valid,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    // A valid producer that writes a non-zero rd read by a consumer operand
    function automatic logic reg_hit(
        input logic              valid,
        input logic              regwrite,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs,
        input logic              used
    );
        return valid & regwrite & used & (rd != {REG_AW{1'b0}}) & (rd == rs);
    endfunction

    logic     mem_busy;
    logic     tkn;
    logic     de_hit_ex;
    logic     raw_hazard;
    logic     raw_stall;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    otter_dmem_wait #(
        .DMEM_LAT (DMEM_LAT)
    ) u_dmem_wait (
        .CLK          (CLK),
        .RESET        (RESET),
        .ex_mem_valid (ex_mem_valid),
        .mem_access   (mem_access),
        .mem_busy     (mem_busy)
    );

    // A branch only redirects when it is real and the pipeline is not frozen
    assign tkn = branch_taken & de_ex_valid & ~mem_busy;

    assign de_hit_ex = reg_hit(de_ex_valid, ex_regwrite, ex_rd, de_rs1, de_rs1_used)
                     | reg_hit(de_ex_valid, ex_regwrite, ex_rd, de_rs2, de_rs2_used);

`ifdef OTTER_FORWARD_EN
    // Only a load result is too late to forward into the next instruction
    assign raw_hazard = de_hit_ex & ex_is_load;
`else
    logic de_hit_mem;
    logic de_hit_wb;
    logic unused_fwd_inputs;

    assign de_hit_mem = reg_hit(ex_mem_valid, mem_regwrite, mem_rd, de_rs1, de_rs1_used)
                      | reg_hit(ex_mem_valid, mem_regwrite, mem_rd, de_rs2, de_rs2_used);
    assign de_hit_wb  = reg_hit(mem_wb_valid, wb_regwrite, wb_rd, de_rs1, de_rs1_used)
                      | reg_hit(mem_wb_valid, wb_regwrite, wb_rd, de_rs2, de_rs2_used);

    // Without forwarding, any in-flight producer blocks the reader in DE
    assign raw_hazard = de_hit_ex | de_hit_mem | de_hit_wb;

    // EX operand fields only steer forwarding, which this build does not have
    assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_is_load};
`endif

    // A taken branch squashes the dependent instruction, so it need not wait
    assign raw_stall = raw_hazard & ~tkn & ~mem_busy;

    // Stall priority: reset, memory wait, taken branch, RAW hazard, advance
    always_comb begin
        stall_pc  = 1'b0;
        stall_if  = 1'b0;
        stall_de  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        if (RESET) begin
            stall_pc = 1'b0;
        end else if (mem_busy) begin
            stall_pc  = 1'b1;
            stall_if  = 1'b1;
            stall_de  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (tkn) begin
            stall_pc = 1'b0;
        end else if (raw_stall) begin
            stall_pc = 1'b1;
            stall_if = 1'b1;
            stall_de = 1'b1;
        end else begin
            stall_pc = 1'b0;
        end
    end

    // EX operand sources: the newest valid producer wins
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (RESET) begin
            fwd_a = FWD_RF;
        end else begin
`ifdef OTTER_FORWARD_EN
            if (reg_hit(ex_mem_valid, mem_regwrite, mem_rd, ex_rs1, ex_rs1_used)) begin
                fwd_a = FWD_EXMEM;
            end else if (reg_hit(mem_wb_valid, wb_regwrite, wb_rd, ex_rs1, ex_rs1_used)) begin
                fwd_a = FWD_MEMWB;
            end else begin
                fwd_a = FWD_RF;
            end
            if (reg_hit(ex_mem_valid, mem_regwrite, mem_rd, ex_rs2, ex_rs2_used)) begin
                fwd_b = FWD_EXMEM;
            end else if (reg_hit(mem_wb_valid, wb_regwrite, wb_rd, ex_rs2, ex_rs2_used)) begin
                fwd_b = FWD_MEMWB;
            end else begin
                fwd_b = FWD_RF;
            end
`else
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
`endif
        end
    end

    assign fwd_a_sel = fwd_a;
    assign fwd_b_sel = fwd_b;

    // Shift, hold or squash the per-stage valid bits
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if_de_valid  <= 1'b0;
            de_ex_valid  <= 1'b0;
            ex_mem_valid <= 1'b0;
            mem_wb_valid <= 1'b0;
        end else if (mem_busy) begin
            mem_wb_valid <= 1'b0;
        end else if (tkn) begin
            if_de_valid  <= 1'b0;
            de_ex_valid  <= 1'b0;
            ex_mem_valid <= de_ex_valid;
            mem_wb_valid <= ex_mem_valid;
        end else if (raw_stall) begin
            de_ex_valid  <= 1'b0;
            ex_mem_valid <= de_ex_valid;
            mem_wb_valid <= ex_mem_valid;
        end else begin
            if_de_valid  <= 1'b1;
            de_ex_valid  <= if_de_valid;
            ex_mem_valid <= de_ex_valid;
            mem_wb_valid <= ex_mem_valid;
        end
    end

endmodule
